imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates the single-port, synchronous-read instruction memory between the CPU fetch stage and the program loader/debug port. Grants at most one access per cycle, drives the memory port, and routes each read response, which returns one cycle after the access, back to the requester that issued it. Sits between the fetch stage, the loader, and the instruction RAM.

## Interface
- `BURST_MAX`, default 4: consecutive loader grants allowed while fetch is waiting before fetch is forced through (range 1..255).
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch read request; held with `f_addr` until granted.
- `f_addr` in 16: fetch word address.
- `f_gnt` out 1: fetch access issued this cycle.
- `f_rvalid` out 1: `f_rdata` valid this cycle.
- `f_rdata` out 32: fetch read data.
- `l_req` in 1: loader request; held with `l_we`/`l_addr`/`l_wdata` until granted.
- `l_we` in 1: loader write (1) or read (0).
- `l_addr` in 16: loader word address.
- `l_wdata` in 32: loader write data.
- `l_lock` in 1: program-load mode; fetch is never granted while high.
- `l_gnt` out 1: loader access issued this cycle.
- `l_rvalid` out 1: `l_rdata` valid this cycle (reads only).
- `l_rdata` out 32: loader read data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out 16: memory word address.
- `mem_wd` out 32: memory write data.
- `mem_rd` in 32: memory read data, valid the cycle after a read access.

## Operation
- Grant logic is combinational from requests and registered state. `f_gnt` and `l_gnt` are never high together and are both 0 while `rst_n`=0.
- Priority: loader wins by default. Fetch wins when `f_req`=1, `l_lock`=0, and either `l_req`=0 or `starve_cnt`=`BURST_MAX`.
- `starve_cnt` is 8 bits, resets to 0:
  - incremented on a loader grant while `f_req`=1;
  - cleared on any fetch grant, or on any cycle with `f_req`=0;
  - saturates at `BURST_MAX`;
  - held, not cleared, while `l_lock`=1.
- Memory port:
  - `mem_en`=`f_gnt`|`l_gnt`.
  - `mem_we`=`l_gnt`&`l_we`.
  - `mem_addr`/`mem_wd` are muxed from the granted requester. When neither is granted they are 0.
- Response tracking uses a registered `owner` ∈ {NONE, FETCH, LOADER}, reset NONE. Next value:
  - FETCH on a fetch grant;
  - LOADER on a loader read grant;
  - otherwise NONE (loader writes produce no response).
- `f_rvalid`=(`owner`==FETCH) and `l_rvalid`=(`owner`==LOADER).
- `x_rdata`=`mem_rd` when the matching `x_rvalid`=1, else 0.

## Timing
- Access issues in the grant cycle (cycle N); read data and `rvalid` appear in N+1 for exactly one cycle. A new grant may issue in N+1, giving full throughput of one access per cycle.
- Read-after-write: a loader write in N followed by any read of the same address granted in N+1 or later returns the new data.
- A requester must keep `req` and its address/data stable until `gnt`. Dropping `req` before `gnt` cancels the request with no side effects.
- Reset values:
  - all registered state 0 / NONE;
  - `f_rvalid`, `l_rvalid`, `f_rdata`, `l_rdata` = 0;
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wd` = 0;
  - `f_gnt`, `l_gnt` = 0.
- Reset asserted mid-operation: a pending response from the cycle before reset is discarded, and `owner` is forced to NONE asynchronously.
- `l_lock` rising in the same cycle as a forced fetch turn: lock wins, and the loader is granted if requesting; otherwise no grant.

## Structure
- Shared package `imem_pkg`:
  - `IMEM_ADDR_W`=16 and `IMEM_DATA_W`=32, also used by the instruction memory and fetch stage;
  - enum `imem_owner_t` {OWN_NONE, OWN_FETCH, OWN_LOADER}.
- Single module, no sub-modules. The starvation counter is small enough to live inline.

## Test plan
- Fetch only: `f_req`=1 with addresses 0,1,2 on consecutive cycles. Required: `f_gnt`=1 each cycle; `f_rvalid` in cycles 1..3 with `f_rdata` = mem[0], mem[1], mem[2].
- Loader write then read: write 0xDEADBEEF to 0x0010 in cycle 0, read 0x0010 in cycle 1. Required: `l_rvalid` in cycle 2 with `l_rdata`=0xDEADBEEF; no `l_rvalid` in cycle 1.
- Starvation, `BURST_MAX`=4: `f_req` and `l_req` held high continuously. Required: grant pattern L,L,L,L,F repeating; `f_rvalid` every 5th cycle.
- Lock: `l_lock`=1 and `f_req`=1 for 20 cycles, `l_req` idle. Required: `f_gnt`=0 throughout; first fetch grant occurs the cycle after `l_lock` falls.
- Reset mid-read: fetch granted in cycle N, `rst_n` low in N+1. Required: `f_rvalid`=0 and `f_rdata`=0 immediately; all outputs 0 until release; normal grants resume on the first edge after release.
- Cancel: `l_req` pulsed for one cycle while a fetch burst is being forced. Required: no loader access on the memory port, and `mem_we` never asserted.

Source files
------------

// File: rtl/imem_pkg.sv
// ============================================================================
//  imem_pkg : shared instruction-memory widths and response-owner encoding
//  Rev 1.0
// ============================================================================
`default_nettype none

package imem_pkg;
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } imem_owner_t;
endpackage

`default_nettype wire

// File: rtl/imem_arbiter_if.sv
// ============================================================================
//  imem_arbiter_if : fetch, loader and instruction-RAM port bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface imem_arbiter_if;
  import imem_pkg::*;

  logic                   f_req;
  logic [IMEM_ADDR_W-1:0] f_addr;
  logic                   f_gnt;
  logic                   f_rvalid;
  logic [IMEM_DATA_W-1:0] f_rdata;

  logic                   l_req;
  logic                   l_we;
  logic [IMEM_ADDR_W-1:0] l_addr;
  logic [IMEM_DATA_W-1:0] l_wdata;
  logic                   l_lock;
  logic                   l_gnt;
  logic                   l_rvalid;
  logic [IMEM_DATA_W-1:0] l_rdata;

  logic                   mem_en;
  logic                   mem_we;
  logic [IMEM_ADDR_W-1:0] mem_addr;
  logic [IMEM_DATA_W-1:0] mem_wd;
  logic [IMEM_DATA_W-1:0] mem_rd;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rd,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wd
  );

  // Requester / memory side
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wd
  );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
//  imem_arbiter : single-port instruction RAM arbiter, fetch vs loader
//  Rev 1.0
// ============================================================================
`default_nettype none

module imem_arbiter
  import imem_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  imem_arbiter_if.slave bus
);

  localparam logic [7:0] c_burst_max = 8'(BURST_MAX);

  logic [7:0]  starve_q, starve_d;
  imem_owner_t owner_q, owner_d;

  logic w_f_win;
  logic w_f_gnt;
  logic w_l_gnt;
  logic w_f_rvalid;
  logic w_l_rvalid;

  always_comb begin
    // Fetch only overrides the loader once it has been starved long enough
    w_f_win = bus.f_req && !bus.l_lock && (!bus.l_req || (starve_q == c_burst_max));
    w_f_gnt = rst_n && w_f_win;
    w_l_gnt = rst_n && bus.l_req && !w_f_win;

    starve_d = starve_q;
    if (!bus.l_lock) begin
      if (w_f_gnt || !bus.f_req) begin
        starve_d = '0;
      end else if (w_l_gnt && (starve_q < c_burst_max)) begin
        starve_d = starve_q + 8'd1;
      end
    end

    owner_d = OWN_NONE;
    if (w_f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (w_l_gnt && !bus.l_we) begin
      owner_d = OWN_LOADER;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign w_f_rvalid = (owner_q == OWN_FETCH);
  assign w_l_rvalid = (owner_q == OWN_LOADER);

  assign bus.f_gnt    = w_f_gnt;
  assign bus.l_gnt    = w_l_gnt;
  assign bus.mem_en   = w_f_gnt || w_l_gnt;
  assign bus.mem_we   = w_l_gnt && bus.l_we;
  assign bus.mem_addr = w_f_gnt ? bus.f_addr : (w_l_gnt ? bus.l_addr : '0);
  assign bus.mem_wd   = w_l_gnt ? bus.l_wdata : '0;

  assign bus.f_rvalid = w_f_rvalid;
  assign bus.l_rvalid = w_l_rvalid;
  assign bus.f_rdata  = w_f_rvalid ? bus.mem_rd : '0;
  assign bus.l_rdata  = w_l_rvalid ? bus.mem_rd : '0;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
//  tb_imem_arbiter : directed vectors plus randomized traffic vs a reference model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if bus();

  imem_arbiter #(.BURST_MAX(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Synchronous-read instruction RAM; unwritten words read their seed value
  logic [31:0] ram [0:65535];
  bit          ram_wr [0:65535];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]    <= bus.mem_wd;
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        ram_q <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_word(int'(bus.mem_addr));
      end
    end
  end
  assign bus.mem_rd = ram_q;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: starvation count, expected-response queue, shadow memory
  typedef struct {
    int          due;
    bit          ldr;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  int          starve = 0;
  logic [31:0] shadow [0:65535];
  bit          m_ef, m_el;

  logic        s_fg, s_lg, s_en, s_we, s_frv, s_lrv;
  logic [31:0] s_frd, s_lrd;

  task automatic step();
    resp_t       r;
    bit          ef, el, efv, elv;
    logic [31:0] efd, eld, eaddr, ewd;
    @(negedge clk);
    s_fg = bus.f_gnt;  s_lg = bus.l_gnt;  s_en = bus.mem_en;  s_we = bus.mem_we;
    s_frv = bus.f_rvalid; s_lrv = bus.l_rvalid; s_frd = bus.f_rdata; s_lrd = bus.l_rdata;
    ef = 0; el = 0; efv = 0; elv = 0; efd = '0; eld = '0;
    if (!rst_n) begin
      starve = 0;
      rq.delete();
    end else begin
      ef = bus.f_req && !bus.l_lock && (!bus.l_req || starve == BURST);
      el = bus.l_req && !ef;
      while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.ldr) begin elv = 1; eld = r.data; end
        else       begin efv = 1; efd = r.data; end
      end
    end
    eaddr = ef ? 32'(bus.f_addr) : (el ? 32'(bus.l_addr) : 32'h0);
    ewd   = el ? bus.l_wdata : 32'h0;
    chk("f_gnt",    32'(bus.f_gnt),    32'(ef));
    chk("l_gnt",    32'(bus.l_gnt),    32'(el));
    chk("mem_en",   32'(bus.mem_en),   32'(ef | el));
    chk("mem_we",   32'(bus.mem_we),   32'(el & bus.l_we));
    chk("mem_addr", 32'(bus.mem_addr), eaddr);
    chk("mem_wd",   bus.mem_wd,        ewd);
    chk("f_rvalid", 32'(bus.f_rvalid), 32'(efv));
    chk("f_rdata",  bus.f_rdata,       efd);
    chk("l_rvalid", 32'(bus.l_rvalid), 32'(elv));
    chk("l_rdata",  bus.l_rdata,       eld);
    if (rst_n) begin
      if (ef) rq.push_back('{cyc + 1, 1'b0, shadow[bus.f_addr]});
      if (el && !bus.l_we) rq.push_back('{cyc + 1, 1'b1, shadow[bus.l_addr]});
      if (el && bus.l_we) shadow[bus.l_addr] = bus.l_wdata;
      if (!bus.l_lock) begin
        if (ef || !bus.f_req) starve = 0;
        else if (el && starve < BURST) starve++;
      end
    end
    m_ef = ef;
    m_el = el;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic        fr;
    logic [15:0] fa;
    logic        lr, lw;
    logic [15:0] la;
    logic [31:0] ld;
    logic        lk;
    logic        e_fg, e_lg, e_we, e_frv;
    logic [31:0] e_frd;
    logic        e_lrv;
    logic [31:0] e_lrd;
  } vec_t;

  function automatic vec_t mk(logic fr, logic [15:0] fa, logic lr, logic lw, logic [15:0] la,
                              logic [31:0] ld, logic lk, logic e_fg, logic e_lg, logic e_we,
                              logic e_frv, logic [31:0] e_frd, logic e_lrv, logic [31:0] e_lrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld; v.lk = lk;
    v.e_fg = e_fg; v.e_lg = e_lg; v.e_we = e_we; v.e_frv = e_frv; v.e_frd = e_frd;
    v.e_lrv = e_lrv; v.e_lrd = e_lrd;
    return v;
  endfunction

  task automatic drive_idle();
    bus.f_req = 0; bus.f_addr = '0; bus.l_req = 0; bus.l_we = 0;
    bus.l_addr = '0; bus.l_wdata = '0; bus.l_lock = 0;
  endtask

  vec_t vecs [18];

  initial begin
    drive_idle();
    for (int i = 0; i < 65536; i++) shadow[i] = init_word(i);

    // Fetch-only stream, loader write/read-back, then saturated contention
    vecs[0] = mk(1, 16'h0, 0, 0, 16'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    vecs[1] = mk(1, 16'h1, 0, 0, 16'h0, 32'h0, 0, 1, 0, 0, 1, init_word(0), 0, 32'h0);
    vecs[2] = mk(1, 16'h2, 0, 0, 16'h0, 32'h0, 0, 1, 0, 0, 1, init_word(1), 0, 32'h0);
    vecs[3] = mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 1, init_word(2), 0, 32'h0);
    vecs[4] = mk(0, 16'h0, 1, 1, 16'h10, 32'hDEAD_BEEF, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    vecs[5] = mk(0, 16'h0, 1, 0, 16'h10, 32'h0, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    vecs[6] = mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
    for (int k = 0; k < 10; k++) begin
      vecs[7 + k] = mk(1, 16'h20, 1, 0, 16'h30, 32'h0, 0,
                       (k % 5) == 4, (k % 5) != 4, 0,
                       k == 5, (k == 5) ? init_word('h20) : 32'h0,
                       k >= 1 && k != 5, (k >= 1 && k != 5) ? init_word('h30) : 32'h0);
    end
    vecs[17] = mk(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 0, 1, init_word('h20), 0, 32'h0);

    // Reset: outputs quiet even with both requesters active
    step();
    bus.f_req = 1; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 16'h7;
    step();
    chk("reset_mem_en", 32'(s_en), 32'h0);
    chk("reset_mem_we", 32'(s_we), 32'h0);
    drive_idle();
    rst_n = 1;

    foreach (vecs[i]) begin
      bus.f_req = vecs[i].fr; bus.f_addr = vecs[i].fa; bus.l_req = vecs[i].lr;
      bus.l_we = vecs[i].lw; bus.l_addr = vecs[i].la; bus.l_wdata = vecs[i].ld;
      bus.l_lock = vecs[i].lk;
      step();
      chk($sformatf("vec%0d_f_gnt", i),    32'(s_fg),  32'(vecs[i].e_fg));
      chk($sformatf("vec%0d_l_gnt", i),    32'(s_lg),  32'(vecs[i].e_lg));
      chk($sformatf("vec%0d_mem_we", i),   32'(s_we),  32'(vecs[i].e_we));
      chk($sformatf("vec%0d_f_rvalid", i), 32'(s_frv), 32'(vecs[i].e_frv));
      chk($sformatf("vec%0d_f_rdata", i),  s_frd,      vecs[i].e_frd);
      chk($sformatf("vec%0d_l_rvalid", i), 32'(s_lrv), 32'(vecs[i].e_lrv));
      chk($sformatf("vec%0d_l_rdata", i),  s_lrd,      vecs[i].e_lrd);
    end

    // Lock holds fetch off; fetch goes through the first unlocked cycle
    drive_idle();
    bus.f_req = 1; bus.f_addr = 16'h55; bus.l_lock = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("lock_f_gnt", 32'(s_fg), 32'h0);
    end
    bus.l_lock = 0;
    step();
    chk("unlock_f_gnt", 32'(s_fg), 32'h1);

    // Loader write pulsed during a forced fetch turn, then withdrawn
    bus.f_addr = 16'h40; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 16'h41;
    for (int i = 0; i < BURST; i++) begin
      step();
      chk("cancel_pre_l_gnt", 32'(s_lg), 32'h1);
    end
    bus.l_we = 1; bus.l_addr = 16'h42; bus.l_wdata = 32'hCAFE_F00D;
    step();
    chk("cancel_forced_f_gnt", 32'(s_fg), 32'h1);
    chk("cancel_forced_l_gnt", 32'(s_lg), 32'h0);
    chk("cancel_forced_mem_we", 32'(s_we), 32'h0);
    bus.l_req = 0;
    step();
    chk("cancel_after_l_gnt", 32'(s_lg), 32'h0);
    chk("cancel_after_mem_we", 32'(s_we), 32'h0);
    chk("cancel_ram_untouched", 32'(ram_wr[16'h42]), 32'h0);

    // Reset while a fetch response is due
    drive_idle();
    bus.f_req = 1; bus.f_addr = 16'h5;
    step();
    rst_n = 0;
    #1;
    chk("rst_mid_f_rvalid", 32'(bus.f_rvalid), 32'h0);
    chk("rst_mid_f_rdata",  bus.f_rdata,       32'h0);
    chk("rst_mid_f_gnt",    32'(bus.f_gnt),    32'h0);
    chk("rst_mid_mem_en",   32'(bus.mem_en),   32'h0);
    step();
    step();
    rst_n = 1;
    step();
    chk("rst_release_f_gnt", 32'(s_fg), 32'h1);
    step();
    chk("rst_release_f_rvalid", 32'(s_frv), 32'h1);

    // Randomized traffic honouring hold-until-grant, with occasional cancels
    drive_idle();
    for (int n = 0; n < 3000; n++) begin
      if (!bus.f_req) begin
        if ($urandom_range(3) != 0) begin
          bus.f_req = 1; bus.f_addr = 16'($urandom_range(15));
        end
      end else if ($urandom_range(31) == 0) begin
        bus.f_req = 0;
      end
      if (!bus.l_req) begin
        if ($urandom_range(2) != 0) begin
          bus.l_req = 1; bus.l_we = 1'($urandom_range(1));
          bus.l_addr = 16'($urandom_range(15)); bus.l_wdata = $urandom;
        end
      end else if ($urandom_range(31) == 0) begin
        bus.l_req = 0;
      end
      if ($urandom_range(49) == 0) bus.l_lock = ~bus.l_lock;
      step();
      if (m_ef) bus.f_req = 0;
      if (m_el) bus.l_req = 0;
    end
    drive_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
